matmul_feeder: RTL and testbench
================================

MATMUL_FEEDER -- requirements
Module: matmul_feeder

Interface
REQ-001 SHALL have parameter CAPTURE_DELAY, default 1: cycles after the FLUSH cycle before the result words are sampled; legal range 1..4.
REQ-002 SHALL have the following ports (clock and reset first):
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_data  input  8  operand byte stream.
- in_valid  input  1  in_data valid.
- in_ready  output  1  feeder accepts a byte this cycle.
- out_data  output  8  result byte stream.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- busy  output  1  high in every state except LOAD.
- mm_start  output  1  one-cycle start pulse to the 2x2 array.
- mm_a1, mm_a2, mm_b1, mm_b2  output  8 each  skewed row and column feeds to the array.
- mm_c1..mm_c4  input  16 each  array results C00, C01, C10, C11.

Function
REQ-003 SHALL accept exactly 8 bytes per job, in order A00, A01, A10, A11, B00, B01, B10, B11; a byte transfers when in_valid && in_ready.
REQ-004 SHALL assert in_ready only in LOAD; in_valid SHALL be ignored in all other states.
REQ-005 SHALL sequence states LOAD -> START -> FEED0 -> FEED1 -> FEED2 -> FLUSH -> WAIT -> DRAIN -> LOAD.
REQ-006 SHALL move from LOAD to START on the cycle after the 8th byte transfers.
REQ-007 SHALL drive mm_start=1 only in START; all mm_a/mm_b outputs SHALL be 0 in START.
REQ-008 SHALL drive registered outputs per state:
- FEED0: a1=A00, a2=0, b1=B00, b2=0.
- FEED1: a1=A01, a2=A10, b1=B10, b2=B01.
- FEED2: a1=0, a2=A11, b1=0, b2=B11.
- FLUSH and all other states: all zero.
REQ-009 SHALL hold WAIT for CAPTURE_DELAY cycles, then sample mm_c1..mm_c4 into a 64-bit result register on the final WAIT cycle.
REQ-010 SHALL serialise in DRAIN 8 bytes, little-endian per word: C00[7:0], C00[15:8], C01[7:0], C01[15:8], C10..., C11[15:8].
REQ-011 SHALL hold out_data stable while out_valid && !out_ready.
REQ-012 SHALL return to LOAD on the cycle after the 8th output byte transfers.
REQ-013 SHALL make the FLUSH-to-sample latency CAPTURE_DELAY cycles. Total job latency from START to the first out_valid is 5+CAPTURE_DELAY cycles.
REQ-014 SHALL use 4-bit load and drain byte counters that reset to 0 on every entry to LOAD and DRAIN respectively.
REQ-015 SHALL pass result words through unmodified, including the 16-bit truncation done by the array.

Reset
REQ-016 SHALL, while rst_n=0 at a rising edge, go to LOAD in any state and abandon any partial load or drain.
REQ-017 SHALL clear on reset: counters, operand registers and result register; outputs mm_*=0, out_valid=0, busy=0, out_data=0.
REQ-018 SHALL assert in_ready=1 on the first cycle after rst_n returns high.

Configuration
REQ-019 SHALL, with macro MATMUL_FEEDER_JOBCNT_EN defined, add output job_count (8 bits), reset to 0, incremented when the last DRAIN byte transfers and wrapping 255->0.
REQ-020 SHALL, without MATMUL_FEEDER_JOBCNT_EN, have no job_count port or counter logic.

Structure
REQ-021 SHALL take from shared package matmul_pkg:
- the state enum;
- constants N_OPERAND_BYTES=8, N_RESULT_BYTES=8, DATA_W=8, ACC_W=16.
REQ-022 SHALL be a single module with no sub-module. The serialiser is in-line logic.

Verification
REQ-023 Basic job: bytes 1,2,3,4,5,6,7,8 with a behavioural 2x2 array model -> out bytes 19,0,22,0,43,0,50,0; mm_start seen exactly once.
REQ-024 Overflow job: all bytes 0xFF -> out bytes 02,FC repeated 4 times.
REQ-025 Skew check: bytes 1..8 -> mm_a1/a2/b1/b2 = (1,0,5,0), (2,3,7,6), (0,4,0,8), (0,0,0,0) on FEED0..FLUSH.
REQ-026 Backpressure: random in_valid gaps and out_ready low for 3 cycles mid-drain -> same bytes as REQ-023, no loss or duplication, out_data stable while stalled.
REQ-027 Reset mid-FEED1 and mid-DRAIN -> next cycle in LOAD, outputs zero; a following job yields correct results.
REQ-028 With MATMUL_FEEDER_JOBCNT_EN: 257 jobs -> job_count=1.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and constants for the 2x2 matrix-multiply feeder.
package matmul_pkg;

   localparam int unsigned N_OPERAND_BYTES = 8;
   localparam int unsigned N_RESULT_BYTES  = 8;
   localparam int unsigned DATA_W          = 8;
   localparam int unsigned ACC_W           = 16;
   localparam int unsigned CNT_W           = 4;
   localparam int unsigned OPS_W           = N_OPERAND_BYTES * DATA_W;
   localparam int unsigned RES_W           = 4 * ACC_W;

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_START,
      ST_FEED0,
      ST_FEED1,
      ST_FEED2,
      ST_FLUSH,
      ST_WAIT,
      ST_DRAIN
   } state_t;

   // One cycle of skewed row/column feeds into the array.
   typedef struct packed {
      logic [DATA_W-1:0] a1;
      logic [DATA_W-1:0] a2;
      logic [DATA_W-1:0] b1;
      logic [DATA_W-1:0] b2;
   } feed_t;

   // Operand byte k of the packed operand vector (A00,A01,A10,A11,B00,B01,B10,B11).
   function automatic logic [DATA_W-1:0] op_byte(input logic [OPS_W-1:0] ops, input int unsigned k);
      return ops[k*DATA_W +: DATA_W];
   endfunction

   // Skewed feed pattern for a given state; zero outside FEED0..FEED2.
   function automatic feed_t feed_for(input state_t st, input logic [OPS_W-1:0] ops);
      feed_t f;
      f = '0;
      case (st)
         ST_FEED0: begin
            f.a1 = op_byte(ops, 0);
            f.b1 = op_byte(ops, 4);
         end
         ST_FEED1: begin
            f.a1 = op_byte(ops, 1);
            f.a2 = op_byte(ops, 2);
            f.b1 = op_byte(ops, 6);
            f.b2 = op_byte(ops, 5);
         end
         ST_FEED2: begin
            f.a2 = op_byte(ops, 3);
            f.b2 = op_byte(ops, 7);
         end
         default: f = '0;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/matmul_feeder.sv
// Byte-stream feeder for a 2x2 systolic array: loads 8 operand bytes, drives
// skewed feeds, captures four 16-bit results and drains them as 8 bytes.
// Optional: define MATMUL_FEEDER_JOBCNT_EN to add an 8-bit job_count output.
module matmul_feeder
   import matmul_pkg::*;
#(
   parameter int unsigned CAPTURE_DELAY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              mm_start,
   output logic [DATA_W-1:0] mm_a1,
   output logic [DATA_W-1:0] mm_a2,
   output logic [DATA_W-1:0] mm_b1,
   output logic [DATA_W-1:0] mm_b2,
   input  logic [ACC_W-1:0]  mm_c1,
   input  logic [ACC_W-1:0]  mm_c2,
   input  logic [ACC_W-1:0]  mm_c3,
   input  logic [ACC_W-1:0]  mm_c4
`ifdef MATMUL_FEEDER_JOBCNT_EN
   ,
   output logic [7:0]        job_count
`endif
);

   localparam int unsigned WAIT_W = 3;

   state_t              r_state;
   state_t              w_next;
   feed_t               w_feed;
   feed_t               r_feed;
   logic [CNT_W-1:0]    r_ld_cnt;
   logic [CNT_W-1:0]    r_dr_cnt;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic [OPS_W-1:0]    r_ops;
   logic [RES_W-1:0]    r_result;
   logic                r_in_ready;
   logic                r_busy;
   logic                r_mm_start;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_data;
   logic                w_in_xfer;
   logic                w_out_xfer;
   logic                w_last_load;
   logic                w_last_wait;
   logic                w_last_drain;
   logic [2:0]          w_nxt_idx;

   assign w_in_xfer    = in_valid && r_in_ready;
   assign w_out_xfer   = r_out_valid && out_ready;
   assign w_last_load  = (r_state == ST_LOAD) && w_in_xfer &&
                         (r_ld_cnt == CNT_W'(N_OPERAND_BYTES - 1));
   assign w_last_wait  = (r_state == ST_WAIT) &&
                         (r_wait_cnt == WAIT_W'(CAPTURE_DELAY - 1));
   assign w_last_drain = (r_state == ST_DRAIN) && w_out_xfer &&
                         (r_dr_cnt == CNT_W'(N_RESULT_BYTES - 1));
   assign w_nxt_idx    = 3'(r_dr_cnt[2:0] + 3'd1);

   // Next-state sequencing and the feed pattern for the upcoming state.
   always_comb begin
      w_next = r_state;
      w_feed = '0;
      case (r_state)
         ST_LOAD:  if (w_last_load) w_next = ST_START;
         ST_START: w_next = ST_FEED0;
         ST_FEED0: w_next = ST_FEED1;
         ST_FEED1: w_next = ST_FEED2;
         ST_FEED2: w_next = ST_FLUSH;
         ST_FLUSH: w_next = ST_WAIT;
         ST_WAIT:  if (w_last_wait) w_next = ST_DRAIN;
         ST_DRAIN: if (w_last_drain) w_next = ST_LOAD;
         default:  w_next = ST_LOAD;
      endcase
      w_feed = feed_for(w_next, r_ops);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_LOAD;
      else        r_state <= w_next;
   end

   // Registered control outputs, operand capture, result capture and serialiser.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_in_ready  <= 1'b1;
         r_busy      <= 1'b0;
         r_mm_start  <= 1'b0;
         r_feed      <= '0;
         r_ld_cnt    <= '0;
         r_dr_cnt    <= '0;
         r_wait_cnt  <= '0;
         r_ops       <= '0;
         r_result    <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_in_ready <= (w_next == ST_LOAD);
         r_busy     <= (w_next != ST_LOAD);
         r_mm_start <= (w_next == ST_START);
         r_feed     <= w_feed;

         if (r_state != ST_LOAD) begin
            r_ld_cnt <= '0;
         end else if (w_in_xfer) begin
            r_ops[int'(r_ld_cnt[2:0])*DATA_W +: DATA_W] <= in_data;
            r_ld_cnt <= r_ld_cnt + CNT_W'(1);
         end

         if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
         else                    r_wait_cnt <= '0;

         if (w_last_wait) begin
            r_result    <= {mm_c4, mm_c3, mm_c2, mm_c1};
            r_out_valid <= 1'b1;
            r_out_data  <= mm_c1[DATA_W-1:0];
            r_dr_cnt    <= '0;
         end else if ((r_state == ST_DRAIN) && w_out_xfer) begin
            if (w_last_drain) begin
               r_out_valid <= 1'b0;
               r_out_data  <= '0;
            end else begin
               r_out_data <= r_result[int'(w_nxt_idx)*DATA_W +: DATA_W];
            end
            r_dr_cnt <= r_dr_cnt + CNT_W'(1);
         end
      end
   end

`ifdef MATMUL_FEEDER_JOBCNT_EN
   logic [7:0] r_job_cnt;

   // Completed-job counter, wrapping at 8 bits.
   always_ff @(posedge clk) begin
      if (!rst_n)            r_job_cnt <= '0;
      else if (w_last_drain) r_job_cnt <= r_job_cnt + 8'd1;
   end

   assign job_count = r_job_cnt;
`endif

   assign in_ready  = r_in_ready;
   assign busy      = r_busy;
   assign mm_start  = r_mm_start;
   assign mm_a1     = r_feed.a1;
   assign mm_a2     = r_feed.a2;
   assign mm_b1     = r_feed.b1;
   assign mm_b2     = r_feed.b2;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

endmodule

// File: tb/tb_matmul_feeder.sv
// Scoreboard bench for matmul_feeder with a behavioural 2x2 systolic array.
module tb_matmul_feeder;

   localparam int unsigned CD = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        mm_start;
   logic [7:0]  mm_a1, mm_a2, mm_b1, mm_b2;
   logic [15:0] mm_c1, mm_c2, mm_c3, mm_c4;
`ifdef MATMUL_FEEDER_JOBCNT_EN
   logic [7:0]  job_count;
`endif

   matmul_feeder #(.CAPTURE_DELAY(CD)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .mm_start(mm_start),
      .mm_a1(mm_a1), .mm_a2(mm_a2), .mm_b1(mm_b1), .mm_b2(mm_b2),
      .mm_c1(mm_c1), .mm_c2(mm_c2), .mm_c3(mm_c3), .mm_c4(mm_c4)
`ifdef MATMUL_FEEDER_JOBCNT_EN
      , .job_count(job_count)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int jobs_done = 0;
   bit chk_en = 1'b0;
   logic [63:0] cur_ops;
   logic [7:0]  exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Behavioural 2x2 output-stationary systolic array driving the result inputs.
   logic [7:0]  a1_d, a2_d, b1_d, b2_d;
   logic [15:0] acc00, acc01, acc10, acc11;
   always_ff @(posedge clk) begin
      if (mm_start) begin
         {acc00, acc01, acc10, acc11} <= '0;
         {a1_d, a2_d, b1_d, b2_d} <= '0;
      end else begin
         acc00 <= acc00 + 16'(mm_a1) * 16'(mm_b1);
         acc01 <= acc01 + 16'(a1_d)  * 16'(mm_b2);
         acc10 <= acc10 + 16'(mm_a2) * 16'(b1_d);
         acc11 <= acc11 + 16'(a2_d)  * 16'(b2_d);
         a1_d <= mm_a1; a2_d <= mm_a2; b1_d <= mm_b1; b2_d <= mm_b2;
      end
   end
   assign mm_c1 = acc00;
   assign mm_c2 = acc01;
   assign mm_c3 = acc10;
   assign mm_c4 = acc11;

   function automatic logic [7:0] ob(input logic [63:0] ops, input int k);
      return ops[k*8 +: 8];
   endfunction

   // Reference: plain 2x2 product mod 2^16, pushed as little-endian bytes.
   task automatic push_expected(input logic [63:0] ops);
      logic [15:0] c[4];
      c[0] = 16'(16'(ob(ops,0))*16'(ob(ops,4)) + 16'(ob(ops,1))*16'(ob(ops,6)));
      c[1] = 16'(16'(ob(ops,0))*16'(ob(ops,5)) + 16'(ob(ops,1))*16'(ob(ops,7)));
      c[2] = 16'(16'(ob(ops,2))*16'(ob(ops,4)) + 16'(ob(ops,3))*16'(ob(ops,6)));
      c[3] = 16'(16'(ob(ops,2))*16'(ob(ops,5)) + 16'(ob(ops,3))*16'(ob(ops,7)));
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(c[i][7:0]);
         exp_q.push_back(c[i][15:8]);
      end
   endtask

   // Expected skewed feed {a1,a2,b1,b2} for cycle k after START (0=FEED0 .. 3=FLUSH).
   function automatic logic [31:0] exp_feed(input logic [63:0] ops, input int k);
      case (k)
         0: return {ob(ops,0), 8'd0, ob(ops,4), 8'd0};
         1: return {ob(ops,1), ob(ops,2), ob(ops,6), ob(ops,5)};
         2: return {8'd0, ob(ops,3), 8'd0, ob(ops,7)};
         default: return 32'd0;
      endcase
   endfunction

   // Monitor: scoreboard pops, stall stability, skew, latency and handshake checks.
   int   feed_ph = 0;
   int   start_cyc = 0;
   int   n_starts = 0;
   bit   pv = 1'b0, pstall = 1'b0;
   logic [7:0] pdata;
   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         chk(in_ready == !busy, "ready_vs_busy", 64'(in_ready), 64'(!busy));
         if (mm_start) begin
            n_starts++;
            start_cyc = cyc;
            feed_ph = 1;
            chk({mm_a1, mm_a2, mm_b1, mm_b2} == 32'd0, "start_feed_zero",
                64'({mm_a1, mm_a2, mm_b1, mm_b2}), 64'd0);
         end else if (feed_ph >= 1 && feed_ph <= 4) begin
            chk({mm_a1, mm_a2, mm_b1, mm_b2} == exp_feed(cur_ops, feed_ph - 1), "skew",
                64'({mm_a1, mm_a2, mm_b1, mm_b2}), 64'(exp_feed(cur_ops, feed_ph - 1)));
            feed_ph++;
         end
         if (out_valid && !pv) begin
            chk(cyc - start_cyc == 5 + CD, "latency", 64'(cyc - start_cyc), 64'(5 + CD));
            chk(n_starts == 1, "start_once", 64'(n_starts), 64'd1);
            n_starts = 0;
         end
         if (pstall)
            chk(out_valid && out_data == pdata, "stall_stable",
                64'({out_valid, out_data}), 64'({1'b1, pdata}));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk(1'b0, "unexpected_byte", 64'(out_data), 64'd0);
            else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               chk(out_data == e, "out_byte", 64'(out_data), 64'(e));
            end
         end
         pv = out_valid;
         pstall = out_valid && !out_ready;
         pdata = out_data;
      end else begin
         pv = 1'b0; pstall = 1'b0; feed_ph = 0; n_starts = 0;
      end
   end

   task automatic check_idle(input string tag);
      chk(in_ready == 1'b1 && busy == 1'b0, {tag, "_ready_busy"}, 64'({in_ready, busy}), 64'b10);
      chk(out_valid == 1'b0 && out_data == 8'd0, {tag, "_out"}, 64'({out_valid, out_data}), 64'd0);
      chk({mm_start, mm_a1, mm_a2, mm_b1, mm_b2} == 33'd0, {tag, "_mm"},
          64'({mm_start, mm_a1, mm_a2, mm_b1, mm_b2}), 64'd0);
   endtask

   // All stimulus tasks start and end at posedge+1.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0; in_data = 8'($urandom); @(posedge clk); #1;
         end
      end
      in_valid = 1'b1; in_data = b; n = 0;
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      if (n >= 100) chk(1'b0, "in_ready_timeout", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_ops(input logic [63:0] ops, input bit gaps);
      for (int k = 0; k < 8; k++) send_byte(ob(ops, k), gaps);
   endtask

   task automatic wait_out_valid();
      int n = 0;
      in_valid = 1'b1; in_data = 8'($urandom);
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      in_valid = 1'b0;
      if (n >= 100) chk(1'b0, "out_valid_timeout", 64'(out_valid), 64'd1);
   endtask

   // Drain up to n_bytes; stall holds out_ready low 3 cycles after byte 3.
   task automatic drain(input int n_bytes, input bit stall, input bit rnd);
      int cnt = 0, st = 0, n = 0;
      bit xfer;
      while (cnt < n_bytes && n < 200) begin
         if (stall && cnt == 3 && st < 3) begin out_ready = 1'b0; st++; end
         else if (rnd) out_ready = ($urandom_range(0, 3) != 0);
         else out_ready = 1'b1;
         xfer = out_valid && out_ready;
         @(posedge clk); #1; n++;
         if (xfer) cnt++;
      end
      if (n >= 200) chk(1'b0, "drain_timeout", 64'(cnt), 64'(n_bytes));
      out_ready = 1'b1;
   endtask

   task automatic run_job(input logic [63:0] ops, input bit gaps, input bit stall, input bit rnd);
      cur_ops = ops;
      push_expected(ops);
      send_ops(ops, gaps);
      wait_out_valid();
      drain(8, stall, rnd);
      jobs_done++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      jobs_done = 0;
   endtask

   logic [63:0] seq_ops;
   initial begin
      int n;
      seq_ops = 64'h0807060504030201;
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
      cur_ops = '0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      rst_n = 1'b1;
      chk(in_ready == 1'b1, "ready_after_reset", 64'(in_ready), 64'd1);
      chk_en = 1'b1;

      run_job(seq_ops, 1'b0, 1'b0, 1'b0);
      run_job({8{8'hFF}}, 1'b0, 1'b0, 1'b0);
      run_job(seq_ops, 1'b1, 1'b1, 1'b0);
      for (int j = 0; j < 10; j++)
         run_job({$urandom, $urandom}, 1'b1, $urandom_range(0, 1) == 1, 1'b1);

      // Reset during FEED1.
      chk_en = 1'b0;
      cur_ops = {$urandom, $urandom};
      send_ops(cur_ops, 1'b0);
      n = 0;
      while (!mm_start && n < 50) begin @(posedge clk); #1; n++; end
      chk(mm_start == 1'b1, "abort_feed_start", 64'(mm_start), 64'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      do_reset();
      check_idle("rst_feed1");
      rst_n = 1'b1;
      chk_en = 1'b1;
      run_job(seq_ops, 1'b0, 1'b0, 1'b0);

      // Reset during DRAIN after three bytes.
      chk_en = 1'b0;
      cur_ops = {$urandom, $urandom};
      send_ops(cur_ops, 1'b0);
      wait_out_valid();
      drain(3, 1'b0, 1'b0);
      chk(out_valid == 1'b1, "abort_in_drain", 64'(out_valid), 64'd1);
      do_reset();
      check_idle("rst_drain");
      rst_n = 1'b1;
      chk_en = 1'b1;
      run_job({$urandom, $urandom}, 1'b1, 1'b1, 1'b0);

`ifdef MATMUL_FEEDER_JOBCNT_EN
      while (jobs_done < 257) run_job({$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
      chk(job_count == 8'd1, "job_count_wrap", 64'(job_count), 64'd1);
`endif

      repeat (2) @(posedge clk);
      #1;
      chk(exp_q.size() == 0, "scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
